// File: rtl/line_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : line_bus_arbiter
// Purpose  : Two-master arbiter that shares one cacheline bus (the cache side
//            of cacheline_adaptor) between the instruction cache (read-only)
//            and the data cache (read + write-back). Exactly one whole line
//            transaction is outstanding at a time. The granted request is
//            latched into the registered ca_* outputs, and the returned line
//            and completion pulse are routed back to the owner.
//
// Ports    : clk, rst_n                  bus clock / async active-low reset
//            i_mem_address, i_mem_read   icache line read request (level)
//            i_mem_rdata, i_mem_resp     line data / 1-cycle done to icache
//            d_mem_address, d_mem_read,
//            d_mem_write, d_mem_wdata    dcache read / write-back request
//            d_mem_rdata, d_mem_resp     line data / 1-cycle done to dcache
//            ca_address, ca_read,
//            ca_write, ca_wdata          registered downstream request
//            ca_rdata, ca_resp           downstream data / completion
//
// Config   : ARB_ROUND_ROBIN_EN - when defined, a tie in IDLE goes to the
//            master that was not granted last. When undefined, the dcache
//            always wins a tie and no last-grant state exists.
//
// Revision : 1.0 - initial release
// ============================================================================
module line_bus_arbiter #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic [ADDR_W-1:0] i_mem_address,
    input  logic              i_mem_read,
    output logic [LINE_W-1:0] i_mem_rdata,
    output logic              i_mem_resp,

    input  logic [ADDR_W-1:0] d_mem_address,
    input  logic              d_mem_read,
    input  logic              d_mem_write,
    input  logic [LINE_W-1:0] d_mem_wdata,
    output logic [LINE_W-1:0] d_mem_rdata,
    output logic              d_mem_resp,

    output logic [ADDR_W-1:0] ca_address,
    output logic              ca_read,
    output logic              ca_write,
    output logic [LINE_W-1:0] ca_wdata,
    input  logic [LINE_W-1:0] ca_rdata,
    input  logic              ca_resp
);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_BUSY_I = 2'd1;
    localparam logic [1:0] c_ST_BUSY_D = 2'd2;
    localparam logic [1:0] c_ST_RESP   = 2'd3;

    logic [1:0] r_state;
    logic [1:0] w_next_state;

    logic w_i_req;
    logic w_d_req;
    logic w_grant_i;
    logic w_grant_d;

    // A dcache request is live for either a refill or a write-back.
    assign w_i_req = i_mem_read;
    assign w_d_req = d_mem_read | d_mem_write;

    // ------------------------------------------------------------------------
    // Arbitration. The grant terms are only acted on while IDLE.
    // ------------------------------------------------------------------------
`ifdef ARB_ROUND_ROBIN_EN
    localparam logic c_GRANT_I = 1'b0;
    localparam logic c_GRANT_D = 1'b1;

    logic r_last_grant;

    // On a tie, hand the bus to whoever did not have it last.
    assign w_grant_d = w_d_req & (~w_i_req | (r_last_grant == c_GRANT_I));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_grant <= c_GRANT_D;
        end else if (r_state == c_ST_IDLE) begin
            if (w_grant_d) begin
                r_last_grant <= c_GRANT_D;
            end else if (w_grant_i) begin
                r_last_grant <= c_GRANT_I;
            end
        end
    end
`else
    // Fixed priority: the dcache wins a tie so that a victim write-back and
    // the refill that follows it stay adjacent on the bus.
    assign w_grant_d = w_d_req;
`endif

    assign w_grant_i = w_i_req & ~w_grant_d;

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_grant_d) begin
                    w_next_state = c_ST_BUSY_D;
                end else if (w_grant_i) begin
                    w_next_state = c_ST_BUSY_I;
                end
            end
            c_ST_BUSY_I,
            c_ST_BUSY_D: begin
                if (ca_resp) begin
                    w_next_state = c_ST_RESP;
                end
            end
            // RESP lasts one cycle. It gives the owner the edge on which it
            // sees its resp pulse and drops its level request, so that the
            // stale request is never re-granted.
            c_ST_RESP: begin
                w_next_state = c_ST_IDLE;
            end
            default: begin
                w_next_state = c_ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Registered datapath: downstream request and per-master return path
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ca_address  <= '0;
            ca_read     <= 1'b0;
            ca_write    <= 1'b0;
            ca_wdata    <= '0;
            i_mem_rdata <= '0;
            i_mem_resp  <= 1'b0;
            d_mem_rdata <= '0;
            d_mem_resp  <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_grant_d) begin
                        // Read and write together is a protocol error. The
                        // write-back is issued so that no dirty data is lost.
                        ca_address <= d_mem_address;
                        ca_write   <= d_mem_write;
                        ca_read    <= ~d_mem_write;
                        ca_wdata   <= d_mem_wdata;
                    end else if (w_grant_i) begin
                        ca_address <= i_mem_address;
                        ca_read    <= 1'b1;
                        ca_write   <= 1'b0;
                        ca_wdata   <= '0;
                    end
                end
                c_ST_BUSY_I: begin
                    // The icache may have dropped its request by now. The
                    // transaction still completes and the pulse still fires.
                    if (ca_resp) begin
                        i_mem_rdata <= ca_rdata;
                        i_mem_resp  <= 1'b1;
                        ca_read     <= 1'b0;
                        ca_write    <= 1'b0;
                    end
                end
                c_ST_BUSY_D: begin
                    if (ca_resp) begin
                        // A write-back returns no line, so the last refill
                        // data stays visible to the dcache.
                        if (!ca_write) begin
                            d_mem_rdata <= ca_rdata;
                        end
                        d_mem_resp <= 1'b1;
                        ca_read    <= 1'b0;
                        ca_write   <= 1'b0;
                    end
                end
                c_ST_RESP: begin
                    i_mem_resp <= 1'b0;
                    d_mem_resp <= 1'b0;
                end
                default: begin
                    i_mem_resp <= 1'b0;
                    d_mem_resp <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_line_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_line_bus_arbiter
// Purpose  : Self-checking bench for line_bus_arbiter. A behavioural line
//            memory answers the downstream bus. Expected completions (owner
//            and returned line) are queued when a request is driven and are
//            checked when a resp pulse appears.
// Revision : 1.0 - initial release
// ============================================================================
module tb_line_bus_arbiter;

    localparam int ADDR_W = 32;
    localparam int LINE_W = 256;

    logic              clk;
    logic              rst_n;
    logic [ADDR_W-1:0] i_mem_address;
    logic              i_mem_read;
    logic [LINE_W-1:0] i_mem_rdata;
    logic              i_mem_resp;
    logic [ADDR_W-1:0] d_mem_address;
    logic              d_mem_read;
    logic              d_mem_write;
    logic [LINE_W-1:0] d_mem_wdata;
    logic [LINE_W-1:0] d_mem_rdata;
    logic              d_mem_resp;
    logic [ADDR_W-1:0] ca_address;
    logic              ca_read;
    logic              ca_write;
    logic [LINE_W-1:0] ca_wdata;
    logic [LINE_W-1:0] ca_rdata;
    logic              ca_resp;

    line_bus_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_mem_address (i_mem_address),
        .i_mem_read    (i_mem_read),
        .i_mem_rdata   (i_mem_rdata),
        .i_mem_resp    (i_mem_resp),
        .d_mem_address (d_mem_address),
        .d_mem_read    (d_mem_read),
        .d_mem_write   (d_mem_write),
        .d_mem_wdata   (d_mem_wdata),
        .d_mem_rdata   (d_mem_rdata),
        .d_mem_resp    (d_mem_resp),
        .ca_address    (ca_address),
        .ca_read       (ca_read),
        .ca_write      (ca_write),
        .ca_wdata      (ca_wdata),
        .ca_rdata      (ca_rdata),
        .ca_resp       (ca_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------------
    // Bookkeeping
    // ------------------------------------------------------------------------
    int checks   = 0;
    int failures = 0;

    typedef struct {
        bit             is_d;
        logic [255:0]   data;
    } exp_t;

    exp_t sb[$];

    typedef struct {
        bit             is_d;
        bit             rd;
        bit             wr;
        logic [31:0]    addr;
        logic [255:0]   wdata;
        logic [255:0]   exp_rdata;
    } vec_t;

    vec_t vecs[7];

    // Behavioural memory behind the bus.
    logic [255:0] mem [logic [31:0]];
    int           mem_latency = 2;
    bit           inject_resp = 1'b0;

    localparam logic [255:0] c_W1 =
        256'h13034532_89abcdef_01234567_deadbeef_cafef00d_0badf00d_76543210_00001908;
    localparam logic [255:0] c_W2 =
        256'hfeedface_11112222_33334444_55556666_77778888_9999aaaa_bbbbcccc_ddddeeee;
    localparam logic [255:0] c_W3 =
        256'h0f0f0f0f_f0f0f0f0_12121212_34343434_56565656_78787878_9a9a9a9a_bcbcbcbc;
    localparam logic [255:0] c_JUNK =
        256'hbad0bad0_bad0bad0_bad0bad0_bad0bad0_bad0bad0_bad0bad0_bad0bad0_bad0bad0;

    function automatic logic [255:0] line_pat(input logic [31:0] a);
        logic [255:0] v;
        for (int k = 0; k < 8; k++) begin
            v[k*32 +: 32] = a ^ (32'h5a5a_0000 + k);
        end
        return v;
    endfunction

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------------------------
    // Downstream responder: answers a read/write after mem_latency cycles
    // with a one-cycle ca_resp. Can also inject a stray ca_resp.
    // ------------------------------------------------------------------------
    initial begin
        int lat_cnt;
        lat_cnt  = 0;
        ca_resp  = 1'b0;
        ca_rdata = '0;
        forever begin
            tick();
            if (inject_resp) begin
                inject_resp = 1'b0;
                ca_resp     = 1'b1;
                ca_rdata    = c_JUNK;
            end else if (ca_resp || !rst_n || !(ca_read || ca_write)) begin
                ca_resp = 1'b0;
                lat_cnt = 0;
            end else begin
                lat_cnt++;
                if (lat_cnt >= mem_latency) begin
                    ca_resp = 1'b1;
                    if (ca_write) begin
                        mem[ca_address] = ca_wdata;
                    end else begin
                        ca_rdata = mem.exists(ca_address) ? mem[ca_address] : line_pat(ca_address);
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Monitor: bus invariants and scoreboard compare on each resp pulse.
    // ------------------------------------------------------------------------
    initial begin
        exp_t e;
        forever begin
            tick();
            if (ca_read && ca_write) begin
                checks++;
                failures++;
                $display("FAIL ca_read_and_write both high at %0t", $time);
            end
            if (i_mem_resp && d_mem_resp) begin
                checks++;
                failures++;
                $display("FAIL resp_overlap both resp high at %0t", $time);
            end
            if (i_mem_resp || d_mem_resp) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_resp i=%0b d=%0b at %0t", i_mem_resp, d_mem_resp, $time);
                end else begin
                    e = sb.pop_front();
                    chk("resp_owner_is_d", d_mem_resp, e.is_d);
                    chk("resp_rdata", e.is_d ? d_mem_rdata : i_mem_rdata, e.data);
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Helpers for the main sequence
    // ------------------------------------------------------------------------
    task automatic wait_resp(input bit is_d, input int budget);
        int cyc;
        bit seen;
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < budget) begin
            tick();
            cyc++;
            seen = is_d ? d_mem_resp : i_mem_resp;
        end
        chk("resp_within_budget", seen, 1'b1);
    endtask

    task automatic do_txn(input vec_t v);
        if (v.is_d) begin
            d_mem_address = v.addr;
            d_mem_read    = v.rd;
            d_mem_write   = v.wr;
            d_mem_wdata   = v.wdata;
        end else begin
            i_mem_address = v.addr;
            i_mem_read    = 1'b1;
        end
        sb.push_back('{v.is_d, v.exp_rdata});
        tick();
        chk("grant_ca_read", ca_read, !v.wr);
        chk("grant_ca_write", ca_write, v.wr);
        chk("grant_ca_address", ca_address, v.addr);
        if (v.wr) chk("grant_ca_wdata", ca_wdata, v.wdata);
        wait_resp(v.is_d, 100);
        i_mem_read  = 1'b0;
        d_mem_read  = 1'b0;
        d_mem_write = 1'b0;
        tick();
    endtask

    // Both masters hold read requests until they have n_i / n_d completions.
    task automatic run_pair(input int n_i, input int n_d, input logic [31:0] ai, input logic [31:0] ad);
        int got_i;
        int got_d;
        int cyc;
        got_i = 0;
        got_d = 0;
        cyc   = 0;
        i_mem_address = ai;
        d_mem_address = ad;
        d_mem_write   = 1'b0;
        i_mem_read    = (n_i > 0);
        d_mem_read    = (n_d > 0);
        while ((got_i < n_i || got_d < n_d) && cyc < 300) begin
            tick();
            cyc++;
            if (i_mem_resp) begin
                got_i++;
                if (got_i >= n_i) i_mem_read = 1'b0;
            end
            if (d_mem_resp) begin
                got_d++;
                if (got_d >= n_d) d_mem_read = 1'b0;
            end
        end
        chk("pair_done_within_budget", (cyc < 300), 1'b1);
        i_mem_read = 1'b0;
        d_mem_read = 1'b0;
        tick();
        tick();
    endtask

    // ------------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------------
    initial begin
        int cyc;

        vecs[0] = '{1'b0, 1'b1, 1'b0, 32'h0000_0020, 256'h0, line_pat(32'h0000_0020)};
        vecs[1] = '{1'b1, 1'b0, 1'b1, 32'h0000_1240, c_W1,   256'h0};
        vecs[2] = '{1'b1, 1'b1, 1'b0, 32'h0000_1240, 256'h0, c_W1};
        vecs[3] = '{1'b0, 1'b1, 1'b0, 32'h0000_0040, 256'h0, line_pat(32'h0000_0040)};
        vecs[4] = '{1'b1, 1'b1, 1'b0, 32'h0000_0080, 256'h0, line_pat(32'h0000_0080)};
        // read+write together: write issued, dcache rdata left unchanged
        vecs[5] = '{1'b1, 1'b1, 1'b1, 32'h0000_2000, c_W2,   line_pat(32'h0000_0080)};
        vecs[6] = '{1'b1, 1'b1, 1'b0, 32'h0000_2000, 256'h0, c_W2};

        rst_n         = 1'b0;
        i_mem_address = '0;
        i_mem_read    = 1'b0;
        d_mem_address = '0;
        d_mem_read    = 1'b0;
        d_mem_write   = 1'b0;
        d_mem_wdata   = '0;

        // Reset state
        repeat (5) tick();
        chk("rst_ca_read", ca_read, 1'b0);
        chk("rst_ca_write", ca_write, 1'b0);
        chk("rst_ca_address", ca_address, 32'h0);
        chk("rst_ca_wdata", ca_wdata, 256'h0);
        chk("rst_i_rdata", i_mem_rdata, 256'h0);
        chk("rst_d_rdata", d_mem_rdata, 256'h0);
        chk("rst_i_resp", i_mem_resp, 1'b0);
        chk("rst_d_resp", d_mem_resp, 1'b0);
        rst_n = 1'b1;
        tick();
        chk("post_rst_ca_read", ca_read, 1'b0);
        chk("post_rst_ca_write", ca_write, 1'b0);

        // Single transactions from the table
        for (int n = 0; n < 7; n++) begin
            do_txn(vecs[n]);
        end

        // Simultaneous requests (last grant was the dcache)
`ifdef ARB_ROUND_ROBIN_EN
        sb.push_back('{1'b0, line_pat(32'h0000_0100)});
        sb.push_back('{1'b1, line_pat(32'h0000_0200)});
`else
        sb.push_back('{1'b1, line_pat(32'h0000_0200)});
        sb.push_back('{1'b0, line_pat(32'h0000_0100)});
`endif
        run_pair(1, 1, 32'h0000_0100, 32'h0000_0200);

        // Continuous re-requests, three transactions each
`ifdef ARB_ROUND_ROBIN_EN
        for (int n = 0; n < 3; n++) begin
            sb.push_back('{1'b0, line_pat(32'h0000_0300)});
            sb.push_back('{1'b1, line_pat(32'h0000_0400)});
        end
`else
        for (int n = 0; n < 3; n++) sb.push_back('{1'b1, line_pat(32'h0000_0400)});
        for (int n = 0; n < 3; n++) sb.push_back('{1'b0, line_pat(32'h0000_0300)});
`endif
        run_pair(3, 3, 32'h0000_0300, 32'h0000_0400);

        // Late completion: icache drops its request mid-transaction
        mem_latency   = 6;
        i_mem_address = 32'h0000_0500;
        i_mem_read    = 1'b1;
        sb.push_back('{1'b0, line_pat(32'h0000_0500)});
        tick();
        chk("late_grant_ca_read", ca_read, 1'b1);
        tick();
        i_mem_read = 1'b0;
        cyc = 0;
        while (!i_mem_resp && cyc < 50) begin
            chk("late_ca_read_held", ca_read, 1'b1);
            tick();
            cyc++;
        end
        chk("late_resp_seen", i_mem_resp, 1'b1);
        tick();
        chk("late_idle_ca_read", ca_read, 1'b0);
        tick();
        chk("late_no_regrant", ca_read, 1'b0);
        mem_latency = 2;

        // Stray ca_resp while idle is ignored
        inject_resp = 1'b1;
        repeat (4) tick();
        chk("stray_i_rdata_kept", i_mem_rdata, line_pat(32'h0000_0500));
        chk("stray_d_rdata_kept", d_mem_rdata, line_pat(32'h0000_0400));
        chk("stray_no_ca_read", ca_read, 1'b0);

        // Reset in the middle of a write-back
        mem_latency   = 20;
        d_mem_address = 32'h0000_3000;
        d_mem_wdata   = c_W3;
        d_mem_write   = 1'b1;
        tick();
        chk("busy_d_ca_write", ca_write, 1'b1);
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_ca_write", ca_write, 1'b0);
        chk("async_rst_ca_read", ca_read, 1'b0);
        chk("async_rst_d_resp", d_mem_resp, 1'b0);
        chk("async_rst_d_rdata", d_mem_rdata, 256'h0);
        d_mem_write = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (10) tick();
        chk("after_rst_ca_write", ca_write, 1'b0);
        chk("after_rst_d_resp", d_mem_resp, 1'b0);
        mem_latency = 2;

        chk("scoreboard_drained", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
